// File: rtl/trigout_pulse_gen.sv
// trigout_pulse_gen: one programmable-width trigger pulse per waveform-period
// Start strobe, as a finite burst or indefinitely. Every output is registered.
// Optional feature: define TRIG_DELAY_EN to add the Delay port and the DELAY
// state (Start-to-pulse delay in clocks).
module trigout_pulse_gen #(
    parameter int WIDTH_BITS = 16,
    parameter int COUNT_BITS = 16,
    parameter int DELAY_BITS = 16
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  EN,
    input  logic                  Start,
    input  logic                  Infinite,
    input  logic [COUNT_BITS-1:0] Burst_Count,
    input  logic [WIDTH_BITS-1:0] Pulse_Width,
`ifdef TRIG_DELAY_EN
    input  logic [DELAY_BITS-1:0] Delay,
`endif
    output logic                  Trig_Out,
    output logic                  Busy,
    output logic                  Done,
    output logic [COUNT_BITS-1:0] Pulse_Num,
    output logic                  Overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_HIGH  = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t                state_q;
    logic                  trig_q;
    logic                  busy_q;
    logic                  done_q;
    logic [COUNT_BITS-1:0] pnum_q;
    logic                  overrun_q;

    // Configuration latched at arm time, held for the whole burst.
    logic [WIDTH_BITS-1:0] wlast_q;    // effective pulse width minus one
    logic [COUNT_BITS-1:0] burst_q;
    logic                  inf_q;
    logic [WIDTH_BITS-1:0] wcnt_q;     // remaining high cycles minus one

`ifdef TRIG_DELAY_EN
    logic [DELAY_BITS-1:0] delay_q;
    logic [DELAY_BITS-1:0] dcnt_q;     // remaining delay cycles minus one
`else
    wire  [DELAY_BITS-1:0] unused_delay = '0;
`endif

    // A zero width behaves as a width of one, so the reload value is width-1
    // with zero clamped.
    logic [WIDTH_BITS-1:0] wlast_d;
    logic [COUNT_BITS-1:0] pnum_d;
    logic                  burst_end_d;

    // Next-value helpers for the width reload and the pulse counter.
    always_comb begin
        wlast_d     = (Pulse_Width == '0) ? '0 : Pulse_Width - WIDTH_BITS'(1);
        pnum_d      = pnum_q + COUNT_BITS'(1);
        burst_end_d = !inf_q && (pnum_d == burst_q);
    end

    // Pulse sequencing FSM with registered outputs; EN low aborts quietly.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            trig_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pnum_q    <= '0;
            overrun_q <= 1'b0;
            wlast_q   <= '0;
            burst_q   <= '0;
            inf_q     <= 1'b0;
            wcnt_q    <= '0;
`ifdef TRIG_DELAY_EN
            delay_q   <= '0;
            dcnt_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (!EN) begin
                state_q   <= S_IDLE;
                trig_q    <= 1'b0;
                busy_q    <= 1'b0;
                pnum_q    <= '0;
                overrun_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (Start) begin
                            if (!Infinite && (Burst_Count == '0)) begin
                                // Empty finite burst: report completion, no pulse.
                                done_q <= 1'b1;
                            end else begin
                                wlast_q <= wlast_d;
                                burst_q <= Burst_Count;
                                inf_q   <= Infinite;
                                pnum_q  <= '0;
                                busy_q  <= 1'b1;
`ifdef TRIG_DELAY_EN
                                delay_q <= Delay;
                                if (Delay != '0) begin
                                    state_q <= S_DELAY;
                                    dcnt_q  <= Delay - DELAY_BITS'(1);
                                end else begin
                                    state_q <= S_HIGH;
                                    trig_q  <= 1'b1;
                                    wcnt_q  <= wlast_d;
                                end
`else
                                state_q <= S_HIGH;
                                trig_q  <= 1'b1;
                                wcnt_q  <= wlast_d;
`endif
                            end
                        end
                    end
`ifdef TRIG_DELAY_EN
                    S_DELAY: begin
                        if (Start) begin
                            overrun_q <= 1'b1;
                        end
                        if (dcnt_q == '0) begin
                            state_q <= S_HIGH;
                            trig_q  <= 1'b1;
                            wcnt_q  <= wlast_q;
                        end else begin
                            dcnt_q <= dcnt_q - DELAY_BITS'(1);
                        end
                    end
`endif
                    S_HIGH: begin
                        if (Start) begin
                            overrun_q <= 1'b1;
                        end
                        if (wcnt_q == '0) begin
                            trig_q <= 1'b0;
                            pnum_q <= pnum_d;
                            if (burst_end_d) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_WAIT;
                            end
                        end else begin
                            wcnt_q <= wcnt_q - WIDTH_BITS'(1);
                        end
                    end
                    S_WAIT: begin
                        if (Start) begin
`ifdef TRIG_DELAY_EN
                            if (delay_q != '0) begin
                                state_q <= S_DELAY;
                                dcnt_q  <= delay_q - DELAY_BITS'(1);
                            end else begin
                                state_q <= S_HIGH;
                                trig_q  <= 1'b1;
                                wcnt_q  <= wlast_q;
                            end
`else
                            state_q <= S_HIGH;
                            trig_q  <= 1'b1;
                            wcnt_q  <= wlast_q;
`endif
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        trig_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Trig_Out  = trig_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Pulse_Num = pnum_q;
    assign Overrun   = overrun_q;

endmodule

// File: tb/tb_trigout_pulse_gen.sv
// Directed bench for trigout_pulse_gen (COUNT_BITS=4 so counter wrap is reachable).
module tb_trigout_pulse_gen;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        EN;
    logic        Start;
    logic        Infinite;
    logic [3:0]  Burst_Count;
    logic [15:0] Pulse_Width;
`ifdef TRIG_DELAY_EN
    logic [15:0] Delay;
`endif
    logic        Trig_Out;
    logic        Busy;
    logic        Done;
    logic [3:0]  Pulse_Num;
    logic        Overrun;

    int vectors = 0;
    int miscompares = 0;

    trigout_pulse_gen #(
        .WIDTH_BITS(16),
        .COUNT_BITS(4),
        .DELAY_BITS(16)
    ) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .EN         (EN),
        .Start      (Start),
        .Infinite   (Infinite),
        .Burst_Count(Burst_Count),
        .Pulse_Width(Pulse_Width),
`ifdef TRIG_DELAY_EN
        .Delay      (Delay),
`endif
        .Trig_Out   (Trig_Out),
        .Busy       (Busy),
        .Done       (Done),
        .Pulse_Num  (Pulse_Num),
        .Overrun    (Overrun)
    );

    always #5 Clock = ~Clock;

    // Advance one clock; outputs are then settled from that edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Abort any burst through EN, then re-arm.
    task automatic clear_state();
        Start = 1'b0;
        EN    = 1'b0;
        tick();
        EN    = 1'b1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; EN = 1'b0; Start = 1'b0; Infinite = 1'b0;
        Burst_Count = 4'd0; Pulse_Width = 16'd0;
`ifdef TRIG_DELAY_EN
        Delay = 16'd0;
`endif
        tick(); tick();
        vectors++;
        if ({Trig_Out, Busy, Done, Pulse_Num, Overrun} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state: got %b want 00000000", {Trig_Out, Busy, Done, Pulse_Num, Overrun});
        end
        Reset_n = 1'b1;
        EN = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        clear_state();
        Burst_Count = 4'd2; Pulse_Width = 16'd5; Infinite = 1'b0;
        Start = 1'b1; tick();          // cycle 1, pulse high
        tick();                        // cycle 2, second Start seen in HIGH
        Start = 1'b0;
        vectors++;
        if ({Trig_Out, Busy, Overrun} !== 3'b111) begin
            miscompares++;
            $display("FAIL async_pre: got %b want 111", {Trig_Out, Busy, Overrun});
        end
        #2 Reset_n = 1'b0;
        #1;
        vectors++;
        if ({Trig_Out, Busy, Done, Pulse_Num, Overrun} !== 8'h00) begin
            miscompares++;
            $display("FAIL async_reset: got %b want 00000000", {Trig_Out, Busy, Done, Pulse_Num, Overrun});
        end
        tick();
        Reset_n = 1'b1;
        tick();
        vectors++;
        if ({Trig_Out, Busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL async_release: got %b want 00", {Trig_Out, Busy});
        end
    endtask

    task automatic test_burst();
        clear_state();
        Burst_Count = 4'd3; Pulse_Width = 16'd4; Infinite = 1'b0;
        for (int p = 0; p < 3; p++) begin
            Start = 1'b1;
            tick();
            Start = 1'b0;
            for (int c = 1; c <= 10; c++) begin
                if (p == 0 && c == 1) begin
                    Pulse_Width = 16'd7;   // must not affect the running burst
                    Burst_Count = 4'd9;
                end
                vectors++;
                if (Trig_Out !== (c <= 4)) begin
                    miscompares++;
                    $display("FAIL burst_trig p=%0d c=%0d: got %b want %b", p, c, Trig_Out, (c <= 4));
                end
                vectors++;
                if (Done !== (p == 2 && c == 5)) begin
                    miscompares++;
                    $display("FAIL burst_done p=%0d c=%0d: got %b want %b", p, c, Done, (p == 2 && c == 5));
                end
                if (c == 5 || c == 10) begin
                    vectors++;
                    if (Pulse_Num !== 4'(p + 1)) begin
                        miscompares++;
                        $display("FAIL burst_pnum p=%0d c=%0d: got %0d want %0d", p, c, Pulse_Num, p + 1);
                    end
                    vectors++;
                    if (Busy !== (p != 2)) begin
                        miscompares++;
                        $display("FAIL burst_busy p=%0d c=%0d: got %b want %b", p, c, Busy, (p != 2));
                    end
                end
                if (c != 10) tick();
            end
        end
    endtask

    task automatic test_infinite_wrap();
        clear_state();
        Burst_Count = 4'd3; Pulse_Width = 16'd0; Infinite = 1'b1;
        for (int i = 0; i < 20; i++) begin
            Start = 1'b1;
            tick();
            Start = 1'b0;
            vectors++;
            if ({Trig_Out, Done} !== 2'b10) begin
                miscompares++;
                $display("FAIL inf_high i=%0d: got %b want 10", i, {Trig_Out, Done});
            end
            tick();
            vectors++;
            if ({Trig_Out, Done, Busy, Pulse_Num} !== {3'b001, 4'((i + 1) % 16)}) begin
                miscompares++;
                $display("FAIL inf_low i=%0d: got %b want %b", i, {Trig_Out, Done, Busy, Pulse_Num}, {3'b001, 4'((i + 1) % 16)});
            end
            tick();
        end
    endtask

    task automatic test_overrun();
        clear_state();
        Burst_Count = 4'd2; Pulse_Width = 16'd5; Infinite = 1'b0;
        Start = 1'b1; tick(); Start = 1'b0;        // cycle 1
        for (int c = 1; c <= 8; c++) begin
            if (c == 2) Start = 1'b1;              // sampled at end of cycle 2
            if (c == 3) Start = 1'b0;
            vectors++;
            if ({Trig_Out, Overrun} !== {(c <= 5), (c >= 3)}) begin
                miscompares++;
                $display("FAIL ovr_trig c=%0d: got %b want %b", c, {Trig_Out, Overrun}, {(c <= 5), (c >= 3)});
            end
            if (c == 6) begin
                vectors++;
                if ({Busy, Done, Pulse_Num} !== 6'b10_0001) begin
                    miscompares++;
                    $display("FAIL ovr_count: got %b want 100001", {Busy, Done, Pulse_Num});
                end
            end
            if (c != 8) tick();
        end
        EN = 1'b0; tick(); EN = 1'b1;
        vectors++;
        if ({Trig_Out, Busy, Done, Pulse_Num, Overrun} !== 8'h00) begin
            miscompares++;
            $display("FAIL ovr_clear: got %b want 00000000", {Trig_Out, Busy, Done, Pulse_Num, Overrun});
        end
    endtask

    task automatic test_abort();
        clear_state();
        Burst_Count = 4'd4; Pulse_Width = 16'd3; Infinite = 1'b0;
        Start = 1'b1; tick(); Start = 1'b0;        // cycle 1
        tick(); tick(); tick();                    // cycle 4
        vectors++;
        if ({Trig_Out, Pulse_Num} !== 5'b0_0001) begin
            miscompares++;
            $display("FAIL abort_first: got %b want 00001", {Trig_Out, Pulse_Num});
        end
        Start = 1'b1; tick(); Start = 1'b0;        // second pulse high
        vectors++;
        if ({Trig_Out, Busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL abort_second: got %b want 11", {Trig_Out, Busy});
        end
        EN = 1'b0; tick();
        vectors++;
        if ({Trig_Out, Busy, Done, Pulse_Num} !== 7'b0) begin
            miscompares++;
            $display("FAIL abort_en0: got %b want 0000000", {Trig_Out, Busy, Done, Pulse_Num});
        end
        tick();
        vectors++;
        if (Done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_nodone: got %b want 0", Done);
        end
        EN = 1'b1; Start = 1'b1; tick(); Start = 1'b0;
        vectors++;
        if ({Trig_Out, Busy, Pulse_Num} !== 6'b11_0000) begin
            miscompares++;
            $display("FAIL abort_rearm: got %b want 110000", {Trig_Out, Busy, Pulse_Num});
        end
        tick(); tick(); tick();
        vectors++;
        if ({Trig_Out, Busy, Done, Pulse_Num} !== 7'b010_0001) begin
            miscompares++;
            $display("FAIL abort_fresh: got %b want 0100001", {Trig_Out, Busy, Done, Pulse_Num});
        end
    endtask

    task automatic test_zero_burst();
        clear_state();
        Burst_Count = 4'd0; Pulse_Width = 16'd3; Infinite = 1'b0;
        Start = 1'b1; tick(); Start = 1'b0;
        vectors++;
        if ({Trig_Out, Busy, Done} !== 3'b001) begin
            miscompares++;
            $display("FAIL zero_burst: got %b want 001", {Trig_Out, Busy, Done});
        end
        tick();
        vectors++;
        if ({Trig_Out, Busy, Done} !== 3'b000) begin
            miscompares++;
            $display("FAIL zero_after: got %b want 000", {Trig_Out, Busy, Done});
        end
    endtask

`ifdef TRIG_DELAY_EN
    task automatic test_delay();
        clear_state();
        Burst_Count = 4'd1; Pulse_Width = 16'd2; Infinite = 1'b0; Delay = 16'd3;
        Start = 1'b1; tick(); Start = 1'b0;        // cycle 1
        for (int c = 1; c <= 6; c++) begin
            if (c == 1) Start = 1'b1;              // Start during DELAY
            if (c == 2) Start = 1'b0;
            vectors++;
            if ({Trig_Out, Busy, Done} !== {(c == 4 || c == 5), (c <= 5), (c == 6)}) begin
                miscompares++;
                $display("FAIL delay3 c=%0d: got %b want %b", c, {Trig_Out, Busy, Done}, {(c == 4 || c == 5), (c <= 5), (c == 6)});
            end
            if (c == 2) begin
                vectors++;
                if (Overrun !== 1'b1) begin
                    miscompares++;
                    $display("FAIL delay_ovr: got %b want 1", Overrun);
                end
            end
            if (c != 6) tick();
        end
        clear_state();
        Delay = 16'd0;
        Start = 1'b1; tick(); Start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            vectors++;
            if ({Trig_Out, Done} !== {(c <= 2), (c == 3)}) begin
                miscompares++;
                $display("FAIL delay0 c=%0d: got %b want %b", c, {Trig_Out, Done}, {(c <= 2), (c == 3)});
            end
            if (c != 3) tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_async_reset();
        test_burst();
        test_infinite_wrap();
        test_overrun();
        test_abort();
        test_zero_burst();
`ifdef TRIG_DELAY_EN
        test_delay();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
